// File: rtl/game_pkg.sv
// game_pkg: shared round states, field widths and mode encodings for the round controller
package game_pkg;
   typedef enum logic [1:0] {IDLE, PLAY, WON, LOST} round_state_t;
   localparam int SCORE_W = 4;
   localparam int LIVES_W = 2;
   localparam int TIME_W  = 10;
   localparam logic MODE_EASY = 1'b0;
   localparam logic MODE_HARD = 1'b1;
endpackage

// File: rtl/game_round_ctrl_tick_prescaler.sv
// tick_prescaler: divides clk into a one-cycle game tick, held cleared while disabled
module tick_prescaler #(
   parameter int TICK_DIV = 50
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   output logic tick
);
   localparam int CW = $clog2(TICK_DIV);
   logic [CW-1:0] cnt;
   assign tick = en && (cnt == CW'(TICK_DIV - 1));
   // count 0..TICK_DIV-1 while enabled; restart from 0 whenever disabled
   always_ff @(posedge clk or negedge reset)
      if (!reset) cnt <= '0;
      else        cnt <= (!en || tick) ? '0 : cnt + CW'(1);
endmodule

// File: rtl/game_round_ctrl.sv
// game_round_ctrl: key edge requests, timed scoring round and terminal win/lose pulses
module game_round_ctrl
   import game_pkg::*;
#(
   parameter int TICK_DIV    = 50,
   parameter int ROUND_TICKS = 200,
   parameter int WIN_SCORE   = 10,
   parameter int EASY_LIVES  = 3,
   parameter int HARD_LIVES  = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode_key,
   input  logic               hit,
   input  logic               miss,
   input  logic               modeChoice,
   output logic               on,
   output logic               off,
   output logic               winGame,
   output logic               loseGame,
   output logic               playing,
   output logic [SCORE_W-1:0] score,
   output logic [LIVES_W-1:0] lives,
   output logic [TIME_W-1:0]  time_left
);
   localparam logic [SCORE_W-1:0] WS = SCORE_W'(WIN_SCORE);
   localparam logic [LIVES_W-1:0] EL = LIVES_W'(EASY_LIVES);
   localparam logic [LIVES_W-1:0] HL = LIVES_W'(HARD_LIVES);
   localparam logic [TIME_W-1:0]  RT = TIME_W'(ROUND_TICKS);
   round_state_t       state, state_n;
   logic               prev_start, prev_mode_key, tick;
   logic               on_n, off_n, win_n, lose_n;
   logic [SCORE_W-1:0] score_n;
   logic [LIVES_W-1:0] lives_n;
   logic [TIME_W-1:0]  time_n;
   wire start_rise = start && !prev_start;
   wire key_rise   = mode_key && !prev_mode_key;
   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk  (clk),
      .reset(reset),
      .en   (state == PLAY),
      .tick (tick)
   );
   // next round state, counters and pulses; lose outranks win in the same cycle
   always_comb begin
      state_n = state;
      score_n = score;
      lives_n = lives;
      time_n  = time_left;
      on_n    = 1'b0;
      off_n   = 1'b0;
      win_n   = 1'b0;
      lose_n  = 1'b0;
      case (state)
         IDLE: begin
            on_n  = key_rise && (modeChoice == MODE_EASY);
            off_n = key_rise && (modeChoice == MODE_HARD);
            if (start_rise) begin
               state_n = PLAY;
               score_n = '0;
               lives_n = (modeChoice == MODE_HARD) ? HL : EL;
               time_n  = RT;
            end
         end
         PLAY: begin
            score_n = (hit && score < WS) ? score + SCORE_W'(1) : score;
            lives_n = (miss && lives != '0) ? lives - LIVES_W'(1) : lives;
            time_n  = (tick && time_left != '0) ? time_left - TIME_W'(1) : time_left;
            lose_n  = (lives_n == '0) || (time_n == '0);
            win_n   = !lose_n && (score_n == WS);
            state_n = lose_n ? LOST : win_n ? WON : PLAY;
         end
         default: ;
      endcase
   end
   // register state, edge-detect history and every output
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state         <= IDLE;
         prev_start    <= 1'b0;
         prev_mode_key <= 1'b0;
         on            <= 1'b0;
         off           <= 1'b0;
         winGame       <= 1'b0;
         loseGame      <= 1'b0;
         playing       <= 1'b0;
         score         <= '0;
         lives         <= '0;
         time_left     <= '0;
      end else begin
         state         <= state_n;
         prev_start    <= start;
         prev_mode_key <= mode_key;
         on            <= on_n;
         off           <= off_n;
         winGame       <= win_n;
         loseGame      <= lose_n;
         playing       <= (state_n == PLAY);
         score         <= score_n;
         lives         <= lives_n;
         time_left     <= time_n;
      end
endmodule

// File: tb/tb_game_round_ctrl.sv
// tb_game_round_ctrl: directed checks of mode requests, win, loss, timeout, priority and reset
module tb_game_round_ctrl;
   logic clk = 1'b0, reset = 1'b0;
   logic start = 1'b0, mode_key = 1'b0, hit = 1'b0, miss = 1'b0, modeChoice = 1'b0;
   logic on, off, winGame, loseGame, playing;
   logic [3:0] score;
   logic [1:0] lives;
   logic [9:0] time_left;
   logic t_on, t_off, t_win, t_lose, t_playing;
   logic [3:0] t_score;
   logic [1:0] t_lives;
   logic [9:0] t_time;
   int errors = 0, checks = 0;

   always #5 clk = ~clk;

   game_round_ctrl #(.TICK_DIV(4), .ROUND_TICKS(200)) dut (
      .clk(clk), .reset(reset), .start(start), .mode_key(mode_key), .hit(hit), .miss(miss),
      .modeChoice(modeChoice), .on(on), .off(off), .winGame(winGame), .loseGame(loseGame),
      .playing(playing), .score(score), .lives(lives), .time_left(time_left));

   game_round_ctrl #(.TICK_DIV(4), .ROUND_TICKS(5)) dut_t (
      .clk(clk), .reset(reset), .start(start), .mode_key(mode_key), .hit(hit), .miss(miss),
      .modeChoice(modeChoice), .on(t_on), .off(t_off), .winGame(t_win), .loseGame(t_lose),
      .playing(t_playing), .score(t_score), .lives(t_lives), .time_left(t_time));

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
      step();
   endtask

   initial begin
      repeat (3) step();
      chk("rst_score", int'(score), 0);
      chk("rst_lives", int'(lives), 0);
      chk("rst_time", int'(time_left), 0);
      chk("rst_flags", int'({on, off, winGame, loseGame, playing}), 0);
      reset = 1'b1;
      step();
      // mode toggle requests
      mode_key = 1'b1;
      step();
      chk("on_pulse", int'({on, off}), 2);
      step();
      chk("on_once", int'({on, off}), 0);
      mode_key = 1'b0;
      step();
      modeChoice = 1'b1;
      mode_key = 1'b1;
      step();
      chk("off_pulse", int'({on, off}), 1);
      step();
      chk("off_once", int'({on, off}), 0);
      mode_key = 1'b0;
      modeChoice = 1'b0;
      step();
      // easy round won by ten hits spaced three cycles apart
      start = 1'b1;
      step();
      start = 1'b0;
      chk("play_lives", int'(lives), 3);
      chk("play_time", int'(time_left), 200);
      chk("play_flag", int'(playing), 1);
      for (int i = 1; i <= 10; i++) begin
         hit = 1'b1;
         step();
         hit = 1'b0;
         chk("hit_score", int'(score), i);
         chk("hit_win", int'(winGame), int'(i == 10));
         chk("hit_playing", int'(playing), int'(i != 10));
         if (i != 10) repeat (2) step();
      end
      chk("win_time", int'(time_left), 193);
      chk("win_nolose", int'(loseGame), 0);
      step();
      chk("win_once", int'(winGame), 0);
      hit = 1'b1;
      step();
      hit = 1'b0;
      chk("won_hold_score", int'(score), 10);
      chk("won_hold_time", int'(time_left), 193);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("won_ignore_start", int'(playing), 0);
      // hard round lost by a single miss
      pulse_reset();
      modeChoice = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("hard_lives", int'(lives), 1);
      miss = 1'b1;
      step();
      miss = 1'b0;
      chk("miss_lives", int'(lives), 0);
      chk("miss_lose", int'(loseGame), 1);
      chk("miss_playing", int'(playing), 0);
      step();
      chk("lose_once", int'(loseGame), 0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("lost_ignore_start", int'(playing), 0);
      chk("lost_hold_lives", int'(lives), 0);
      // timeout on the short-round instance
      pulse_reset();
      modeChoice = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("to_time0", int'(t_time), 5);
      for (int k = 1; k <= 20; k++) begin
         step();
         chk("to_time", int'(t_time), 5 - k / 4);
         chk("to_lose", int'(t_lose), int'(k == 20));
         chk("to_playing", int'(t_playing), int'(k < 20));
      end
      step();
      chk("to_lose_once", int'(t_lose), 0);
      // simultaneous hit and miss at score 9, lives 1: loss wins priority
      pulse_reset();
      start = 1'b1;
      step();
      start = 1'b0;
      hit = 1'b1;
      repeat (9) step();
      hit = 1'b0;
      miss = 1'b1;
      repeat (2) step();
      miss = 1'b0;
      chk("pri_score9", int'(score), 9);
      chk("pri_lives1", int'(lives), 1);
      hit = 1'b1;
      miss = 1'b1;
      step();
      hit = 1'b0;
      miss = 1'b0;
      chk("pri_score", int'(score), 10);
      chk("pri_lives", int'(lives), 0);
      chk("pri_lose", int'(loseGame), 1);
      chk("pri_win", int'(winGame), 0);
      // asynchronous reset mid-round
      pulse_reset();
      start = 1'b1;
      step();
      start = 1'b0;
      hit = 1'b1;
      repeat (5) step();
      hit = 1'b0;
      chk("mid_score5", int'(score), 5);
      reset = 1'b0;
      #1;
      chk("async_score", int'(score), 0);
      chk("async_lives", int'(lives), 0);
      chk("async_time", int'(time_left), 0);
      chk("async_flags", int'({on, off, winGame, loseGame, playing}), 0);
      step();
      reset = 1'b1;
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("fresh_score", int'(score), 0);
      chk("fresh_lives", int'(lives), 3);
      chk("fresh_playing", int'(playing), 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
